// File: rtl/cache_ctrl.sv
// Four-way set-associative cache controller: write-through, no write-allocate, oldest-way victim on fill.
// Define CACHE_CTRL_TIMEOUT_EN to bound the memory wait to TIMEOUT_CYCLES cycles.
module cache_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [31:0] set_addr,
    output logic        set_try_read,
    output logic        set_try_write,
    output logic [7:0]  set_write_data,
    output logic [3:0]  set_fill_way,
    output logic [3:0]  set_reset_age,
    output logic [3:0]  set_increment_age,
    input  logic [7:0]  set_data,
    input  logic [7:0]  set_ages,
    input  logic        set_hit,
    input  logic [3:0]  set_hit_way,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        COMPARE,
        MEM_WAIT,
        FILL,
        DONE
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cache_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    state_t      r_state;
    logic        r_we;
    logic [31:0] r_addr;
    logic [7:0]  r_wdata;
    logic [3:0]  r_victim;
    logic [7:0]  r_cpu_rdata;
    logic        r_cpu_done;
    logic        r_set_try_read;
    logic        r_mem_req;
    logic        r_fill;

`ifdef CACHE_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_cpu_err;
`endif

    // Oldest way wins; strict '>' keeps the lowest index on ties.
    logic [3:0] w_victim;
    logic [1:0] w_best_age;
    always_comb begin
        w_victim   = 4'b0001;
        w_best_age = set_ages[1:0];
        for (int i = 1; i < 4; i++) begin
            if (set_ages[2*i +: 2] > w_best_age) begin
                w_best_age = set_ages[2*i +: 2];
                w_victim   = 4'b0001 << i;
            end
        end
    end

    // Hit-dependent strokes in COMPARE follow set_hit within the same cycle.
    logic w_cmp;
    logic w_cmp_hit;
    logic w_cmp_wr;
    assign w_cmp     = (r_state == COMPARE);
    assign w_cmp_hit = w_cmp && set_hit;
    assign w_cmp_wr  = w_cmp_hit && r_we;

    assign set_addr          = ((r_state == LOOKUP) || w_cmp || r_fill) ? r_addr : 32'd0;
    assign set_try_read      = r_set_try_read;
    assign set_try_write     = w_cmp_wr | r_fill;
    assign set_write_data    = w_cmp_wr ? r_wdata : (r_fill ? r_cpu_rdata : 8'd0);
    assign set_fill_way      = r_fill ? r_victim : 4'd0;
    assign set_reset_age     = w_cmp_hit ? set_hit_way : (r_fill ? r_victim : 4'd0);
    assign set_increment_age = w_cmp_hit ? ~set_hit_way : (r_fill ? ~r_victim : 4'd0);

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_req & r_we;
    assign mem_addr  = r_mem_req ? r_addr : 32'd0;
    assign mem_wdata = r_mem_req ? r_wdata : 8'd0;

    assign cpu_rdata = r_cpu_rdata;
    assign cpu_done  = r_cpu_done;
`ifdef CACHE_CTRL_TIMEOUT_EN
    assign cpu_err   = r_cpu_err;
`else
    assign cpu_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_we           <= 1'b0;
            r_addr         <= 32'd0;
            r_wdata        <= 8'd0;
            r_victim       <= 4'd0;
            r_cpu_rdata    <= 8'd0;
            r_cpu_done     <= 1'b0;
            r_set_try_read <= 1'b0;
            r_mem_req      <= 1'b0;
            r_fill         <= 1'b0;
`ifdef CACHE_CTRL_TIMEOUT_EN
            r_wd_cnt       <= '0;
            r_cpu_err      <= 1'b0;
`endif
        end else begin
            r_set_try_read <= 1'b0;
            r_fill         <= 1'b0;
            r_cpu_done     <= 1'b0;
`ifdef CACHE_CTRL_TIMEOUT_EN
            r_cpu_err      <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (cpu_req) begin
                        r_we           <= cpu_we;
                        r_addr         <= cpu_addr;
                        r_wdata        <= cpu_wdata;
                        r_set_try_read <= 1'b1;
                        r_state        <= LOOKUP;
                    end
                end
                LOOKUP: r_state <= COMPARE;
                COMPARE: begin
                    if (!r_we && set_hit) begin
                        r_cpu_rdata <= set_data;
                        r_cpu_done  <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        if (!r_we) begin
                            r_victim <= w_victim;
                        end
                        r_mem_req <= 1'b1;
                        r_state   <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
`ifdef CACHE_CTRL_TIMEOUT_EN
                        r_wd_cnt  <= '0;
`endif
                        if (r_we) begin
                            r_cpu_done <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_cpu_rdata <= mem_rdata;
                            r_fill      <= 1'b1;
                            r_state     <= FILL;
                        end
                    end
`ifdef CACHE_CTRL_TIMEOUT_EN
                    else if (r_wd_cnt == WD_LAST) begin
                        // Give up on memory: no fill, report the error with zero data.
                        r_mem_req   <= 1'b0;
                        r_wd_cnt    <= '0;
                        r_cpu_rdata <= 8'd0;
                        r_cpu_err   <= 1'b1;
                        r_cpu_done  <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
`endif
                end
                FILL: begin
                    r_cpu_done <= 1'b1;
                    r_state    <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
